// File: rtl/bpsk_modulator.sv
// bpsk_modulator: serializes one DATA_W-bit word MSB-first onto a BPSK carrier.
// Each bit spans one full carrier period of 2^SPB_LOG2 output samples, and one
// sample is produced per out_strobe tick. While no frame is running the output is silence.
// Optional feature macro: BPSK_PREAMBLE_EN adds a 4-bit 1,0,1,0 sync preamble
// (state SYNC) ahead of the data bits.

module bpsk_modulator #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SPB_LOG2 = 3,
  parameter int unsigned AMP      = 4194304
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_strobe,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int unsigned PH_W  = SPB_LOG2;
  localparam int unsigned SPB   = 1 << SPB_LOG2;
  localparam int unsigned BIT_W = (DATA_W > 4) ? $clog2(DATA_W) : 2;

  // Carrier magnitudes: H approximates AMP*sin(45deg) using 181/256.
  localparam longint unsigned H_L  = (64'(AMP) * 64'd181) >> 8;
  localparam logic [DATA_W-1:0] C_AMP  = DATA_W'(AMP);
  localparam logic [DATA_W-1:0] C_H    = DATA_W'(H_L);
  localparam logic [DATA_W-1:0] C_NAMP = DATA_W'(0) - C_AMP;
  localparam logic [DATA_W-1:0] C_NH   = DATA_W'(0) - C_H;

`ifdef BPSK_PREAMBLE_EN
  localparam int unsigned SYNC_BITS = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd2
  } state_t;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shift_reg;
  logic [PH_W-1:0]   phase_cnt;
  logic [BIT_W-1:0]  bit_cnt;

  logic              capture;
  logic              busy;
  logic              phase_last;
  logic              bit_last;
  logic              cur_bit;
  logic [2:0]        tbl_idx;
  logic [DATA_W-1:0] carrier;
  logic [DATA_W-1:0] sample;

  assign in_ready   = (state == IDLE);
  assign capture    = in_valid && in_ready;
  assign phase_last = (phase_cnt == PH_W'(SPB - 1));

  // Top three phase bits select one of eight carrier points per period.
  assign tbl_idx = phase_cnt[PH_W-1 -: 3];

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, current bit and last-bit decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    cur_bit   = 1'b0;
    bit_last  = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
`ifdef BPSK_PREAMBLE_EN
          state_nxt = SYNC;
`else
          state_nxt = DATA;
`endif
        end
      end
`ifdef BPSK_PREAMBLE_EN
      SYNC: begin
        busy     = 1'b1;
        cur_bit  = ~bit_cnt[0];
        bit_last = (bit_cnt == BIT_W'(SYNC_BITS - 1));
        if (out_strobe && phase_last && bit_last) begin
          state_nxt = DATA;
        end
      end
`endif
      DATA: begin
        busy     = 1'b1;
        cur_bit  = shift_reg[DATA_W-1];
        bit_last = (bit_cnt == BIT_W'(DATA_W - 1));
        if (out_strobe && phase_last && bit_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Carrier lookup for the current phase point.
  always_comb begin
    carrier = '0;
    case (tbl_idx)
      3'd0:    carrier = '0;
      3'd1:    carrier = C_H;
      3'd2:    carrier = C_AMP;
      3'd3:    carrier = C_H;
      3'd4:    carrier = '0;
      3'd5:    carrier = C_NH;
      3'd6:    carrier = C_NAMP;
      3'd7:    carrier = C_NH;
      default: carrier = '0;
    endcase
  end

  // A zero bit inverts the carrier (180 degree phase shift).
  assign sample = cur_bit ? carrier : (DATA_W'(0) - carrier);

  // Word capture, phase counter and bit counter.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
    end else if (capture) begin
      shift_reg <= in_data;
      phase_cnt <= '0;
      bit_cnt   <= '0;
    end else if (busy && out_strobe) begin
      phase_cnt <= phase_cnt + PH_W'(1);
      if (phase_last) begin
        if (state == DATA) begin
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
        end
        if (bit_last) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

  // Output sample register, updated only on strobes.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (out_strobe) begin
      if (busy) begin
        out_data  <= sample;
        out_valid <= 1'b1;
      end else begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bpsk_modulator.md
# bpsk_modulator

BPSK transmit stage between the codec capture side and the transmit path feeding the receiver chain. It accepts one 24-bit audio word through a valid/ready handshake and serializes it MSB-first. For each output-sample strobe (the codec write_ready tick) it emits one signed 24-bit carrier sample: +carrier for bit 1, −carrier for bit 0. When no frame is in progress it outputs silence (0).

## Interface
Parameters:
- DATA_W, 24: input word width and output sample width.
- SPB_LOG2, 3: log2 of output samples per bit. Legal values are 3, 4 and 5 (8/16/32 samples per bit).
- AMP, 4194304: carrier peak amplitude. Must satisfy 0 < AMP ≤ 2^23−1.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a word to transmit.
- in_ready  out  1  block can accept a word. Combinational: high only in IDLE.
- in_data  in  DATA_W  word to transmit (unsigned bit pattern).
- out_strobe  in  1  one-cycle output-sample tick.
- out_data  out  DATA_W  signed modulated sample, registered.
- out_valid  out  1  registered; high while out_data holds a modulated (non-silence) sample.

## Operation
- States: IDLE, SYNC (compiled only with the macro), DATA.
- Capture rule: in_valid && in_ready at a clock edge loads in_data into a shift register. On the same edge the state moves to SYNC (macro on) or DATA (macro off), and the phase counter and bit counter clear.
- Carrier table, 8 entries indexed 0..7: {0, H, AMP, H, 0, −H, −AMP, −H}, where H = (AMP*181)>>8, computed at elaboration. With the default AMP, H = 2965504.
- Table index = phase_cnt >> (SPB_LOG2−3); phase_cnt counts 0..2^SPB_LOG2−1. Each bit therefore spans exactly one carrier period.
- On each out_strobe in SYNC or DATA:
  - out_data ← current bit ? c[idx] : −c[idx]; out_valid ← 1.
  - phase_cnt increments. On wrap the bit advances: shift register shifts left by 1 in DATA, or the sync index advances in SYNC.
- Current bit is the shift register MSB in DATA, or the sync-pattern bit in SYNC.
- On the strobe that emits the last sample of the last bit, the state moves to IDLE.
- On each out_strobe in IDLE: out_data ← 0, out_valid ← 0.
- Between strobes, out_data and out_valid hold their values.
- Negation is two's complement at DATA_W bits; no saturation is needed because AMP ≤ 2^23−1.

## Timing
- Reset values: out_data=0, out_valid=0, state IDLE, counters 0. in_ready reads 1 during and after reset, but no capture happens while reset_n is low.
- Reset asserted mid-frame: outputs clear immediately (asynchronously) and the frame is discarded. No partial-frame resume.
- Latency: capture edge → busy on the next cycle. The first modulated sample is registered on the first out_strobe strictly after the capture edge. A strobe coincident with the capture edge is treated as an IDLE strobe and outputs 0.
- Frame length: NBITS×2^SPB_LOG2 strobes, where NBITS = DATA_W (macro off) or DATA_W+4 (macro on).
- in_valid while busy is ignored; the word must be held until in_ready. The earliest next capture is the edge after the final-sample strobe.
- A strobe with no frame pending produces silence; strobes are never queued.

## Configuration
- BPSK_PREAMBLE_EN defined: each frame is prefixed by 4 sync bits, 1,0,1,0, in state SYNC before DATA. Frame = DATA_W+4 bits.
- BPSK_PREAMBLE_EN undefined: no SYNC state or logic; capture goes straight to DATA. Frame = DATA_W bits.

## Test plan
- Reset: hold reset_n=0 with strobes running → out_data=0, out_valid=0, in_ready=1. Release → same values until a capture.
- Default params, macro off, capture 24'h800000, strobe every 1042 cycles:
  - strobes 1–8 → 0, 2965504, 4194304, 2965504, 0, −2965504, −4194304, −2965504.
  - strobes 9–16 → 0, −2965504, −4194304, −2965504, 0, 2965504, 4194304, 2965504.
  - strobe 192 is the last with out_valid=1; strobe 193 → out_data=0, out_valid=0, in_ready=1.
- Backpressure: present a second word 24'h000001 at strobe 50 and hold in_valid → not captured until the edge after strobe 192. Its first bits (0) produce negated carrier.
- Reset mid-frame: pull reset_n low after strobe 100 → out_data=0 and out_valid=0 the same cycle. After release, the next strobe outputs 0.
- SPB_LOG2=4, capture 24'hFFFFFF → each table entry repeats on 2 consecutive strobes (0,0,2965504,2965504,…). Frame is 384 strobes, all +carrier.
- BPSK_PREAMBLE_EN defined, capture 24'hFFFFFF → strobes 1–8 +carrier, 9–16 −carrier, 17–24 +carrier, 25–32 −carrier, 33–224 +carrier. Strobe 225 → 0.
